// File: rtl/bottling_ctrl.sv
// Pill-bottling controller: power toggle, per-bottle limit check, paced pill fill,
// bottle-change dwell and an optional batch target that stops in DONE.
module bottling_ctrl #(
    parameter int PILL_W        = 5,
    parameter int BOTTLE_W      = 10,
    parameter int MAX_PILLS     = 20,
    parameter int TICK_DIV      = 4,
    parameter int CHANGE_CYCLES = 2
) (
    input  logic                i_clock,
    input  logic                i_rst_n,
    input  logic                i_powerBtn,
    input  logic                i_restart,
    input  logic                i_pause,
    input  logic [PILL_W-1:0]   i_perBottle,
    input  logic [BOTTLE_W-1:0] i_targetBottles,
    output logic                o_power,
    output logic [2:0]          o_state,
    output logic [PILL_W-1:0]   o_pillCount,
    output logic [BOTTLE_W-1:0] o_bottleCount,
    output logic                o_pillPulse,
    output logic                o_error,
    output logic                o_change,
    output logic                o_done
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_CHECK  = 3'd1,
        ST_FILL   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_DONE   = 3'd4
    } BottleState;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CHG_W  = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CHG_W-1:0]  CHG_LAST  = CHG_W'(CHANGE_CYCLES - 1);
    localparam logic [PILL_W-1:0] PILL_MAX  = PILL_W'(MAX_PILLS);

    logic                r_btnS1;
    logic                r_btnS2;
    logic                r_btnD;
    logic                r_power;
    BottleState          r_state;
    logic [PILL_W-1:0]   r_pillCount;
    logic [BOTTLE_W-1:0] r_bottleCount;
    logic [TICK_W-1:0]   r_tick;
    logic [CHG_W-1:0]    r_chgTimer;
    logic [PILL_W-1:0]   r_limit;
    logic [BOTTLE_W-1:0] r_target;
    logic                r_error;
    logic                r_pillPulse;

    BottleState          w_stateNext;
    logic [PILL_W-1:0]   w_pillNext;
    logic [BOTTLE_W-1:0] w_bottleNext;
    logic [TICK_W-1:0]   w_tickNext;
    logic [CHG_W-1:0]    w_chgNext;
    logic [PILL_W-1:0]   w_limitNext;
    logic [BOTTLE_W-1:0] w_targetNext;
    logic                w_errorNext;
    logic                w_pulseNext;
    logic                w_powerEdge;
    logic [BOTTLE_W-1:0] w_bottleInc;
    logic                w_perBottleBad;

    assign w_powerEdge    = r_btnS2 & ~r_btnD;
    assign w_bottleInc    = r_bottleCount + BOTTLE_W'(1);
    assign w_perBottleBad = (i_perBottle == '0) || (i_perBottle > PILL_MAX);

    // Synchronise the raw button, detect its rising edge and toggle power on it.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btnS1 <= 1'b0;
            r_btnS2 <= 1'b0;
            r_btnD  <= 1'b0;
            r_power <= 1'b0;
        end else begin
            r_btnS1 <= i_powerBtn;
            r_btnS2 <= r_btnS1;
            r_btnD  <= r_btnS2;
            r_power <= r_power ^ w_powerEdge;
        end
    end

    // Next-state and datapath decisions; power-off beats restart, restart beats everything else.
    always_comb begin
        w_stateNext  = r_state;
        w_pillNext   = r_pillCount;
        w_bottleNext = r_bottleCount;
        w_tickNext   = r_tick;
        w_chgNext    = r_chgTimer;
        w_limitNext  = r_limit;
        w_targetNext = r_target;
        w_errorNext  = r_error;
        w_pulseNext  = 1'b0;
        if (!r_power) begin
            w_stateNext  = ST_OFF;
            w_pillNext   = '0;
            w_bottleNext = '0;
            w_tickNext   = '0;
            w_chgNext    = '0;
            w_errorNext  = 1'b0;
        end else if (i_restart && (r_state != ST_OFF)) begin
            w_stateNext  = ST_CHECK;
            w_pillNext   = '0;
            w_bottleNext = '0;
            w_tickNext   = '0;
            w_errorNext  = 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_stateNext = ST_CHECK;
                end
                ST_CHECK: begin
                    w_limitNext  = i_perBottle;
                    w_targetNext = i_targetBottles;
                    if (w_perBottleBad) begin
                        w_errorNext = 1'b1;
                    end else begin
                        w_errorNext = 1'b0;
                        w_tickNext  = '0;
                        w_stateNext = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!i_pause) begin
                        if (r_pillCount == r_limit) begin
                            w_stateNext = ST_CHANGE;
                            w_chgNext   = CHG_LAST;
                        end else if (r_tick == TICK_LAST) begin
                            w_tickNext  = '0;
                            w_pillNext  = r_pillCount + PILL_W'(1);
                            w_pulseNext = 1'b1;
                        end else begin
                            w_tickNext = r_tick + TICK_W'(1);
                        end
                    end
                end
                ST_CHANGE: begin
                    if (!i_pause) begin
                        if (r_chgTimer == '0) begin
                            w_pillNext   = '0;
                            w_bottleNext = w_bottleInc;
                            if ((r_target != '0) && (w_bottleInc == r_target)) begin
                                w_stateNext = ST_DONE;
                            end else begin
                                w_tickNext  = '0;
                                w_stateNext = ST_FILL;
                            end
                        end else begin
                            w_chgNext = r_chgTimer - CHG_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    w_stateNext = ST_DONE;
                end
                default: begin
                    w_stateNext = ST_OFF;
                end
            endcase
        end
    end

    // Register the controller state, counters and strobes.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_OFF;
            r_pillCount   <= '0;
            r_bottleCount <= '0;
            r_tick        <= '0;
            r_chgTimer    <= '0;
            r_limit       <= '0;
            r_target      <= '0;
            r_error       <= 1'b0;
            r_pillPulse   <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_pillCount   <= w_pillNext;
            r_bottleCount <= w_bottleNext;
            r_tick        <= w_tickNext;
            r_chgTimer    <= w_chgNext;
            r_limit       <= w_limitNext;
            r_target      <= w_targetNext;
            r_error       <= w_errorNext;
            r_pillPulse   <= w_pulseNext;
        end
    end

    assign o_power       = r_power;
    assign o_state       = r_state;
    assign o_pillCount   = r_pillCount;
    assign o_bottleCount = r_bottleCount;
    assign o_pillPulse   = r_pillPulse;
    assign o_error       = r_error;
    assign o_change      = (r_state == ST_CHANGE);
    assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_bottling_ctrl.sv
// Scoreboard bench for bottling_ctrl: stimulus queues expected events, a monitor pops them
// whenever the controller changes state, emits a pill strobe or changes its error flag.
module tb_bottling_ctrl;

    localparam int K_STATE = 0;
    localparam int K_PULSE = 1;
    localparam int K_ERROR = 2;

    typedef struct {
        int         kind;
        logic [2:0] st;
        logic       pwr;
        logic [4:0] pill;
        logic [9:0] bottle;
        logic       err;
        int         gap;
    } ExpEvent;

    typedef struct {
        logic [1:0] bottle;
        int         gap;
    } ExpWrap;

    logic       clock;
    logic       rst_n;
    logic       powerBtn, restart, pause;
    logic [4:0] perBottle;
    logic [9:0] targetBottles;
    logic       o_power, o_pillPulse, o_error, o_change, o_done;
    logic [2:0] o_state;
    logic [4:0] o_pillCount;
    logic [9:0] o_bottleCount;

    logic       powerBtn2, restart2, pause2;
    logic [4:0] perBottle2;
    logic [1:0] targetBottles2;
    logic       o_power2, o_pillPulse2, o_error2, o_change2, o_done2;
    logic [2:0] o_state2;
    logic [4:0] o_pillCount2;
    logic [1:0] o_bottleCount2;

    ExpEvent    expQ[$];
    ExpWrap     wrapQ[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         lastCyc = 0;
    int         lastCyc2 = 0;
    int         timeouts = 0;
    bit         finishReq = 1'b0;
    logic [2:0] prevState = 3'd7;
    logic       prevErr = 1'b0;
    logic [1:0] prevBottle2 = 2'd0;

    bottling_ctrl dut (
        .i_clock(clock), .i_rst_n(rst_n), .i_powerBtn(powerBtn), .i_restart(restart),
        .i_pause(pause), .i_perBottle(perBottle), .i_targetBottles(targetBottles),
        .o_power(o_power), .o_state(o_state), .o_pillCount(o_pillCount),
        .o_bottleCount(o_bottleCount), .o_pillPulse(o_pillPulse), .o_error(o_error),
        .o_change(o_change), .o_done(o_done)
    );

    bottling_ctrl #(.BOTTLE_W(2)) dut2 (
        .i_clock(clock), .i_rst_n(rst_n), .i_powerBtn(powerBtn2), .i_restart(restart2),
        .i_pause(pause2), .i_perBottle(perBottle2), .i_targetBottles(targetBottles2),
        .o_power(o_power2), .o_state(o_state2), .o_pillCount(o_pillCount2),
        .o_bottleCount(o_bottleCount2), .o_pillPulse(o_pillPulse2), .o_error(o_error2),
        .o_change(o_change2), .o_done(o_done2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive every input of the main controller at once.
    task automatic applyStimulus(input logic btn, input logic rst, input logic pse,
                                 input logic [4:0] per, input logic [9:0] tgt);
        powerBtn      = btn;
        restart       = rst;
        pause         = pse;
        perBottle     = per;
        targetBottles = tgt;
    endtask

    task automatic pushExp(input int kind, input int st, input int pwr, input int pill,
                           input int bottle, input int err, input int gap);
        ExpEvent e;
        e.kind   = kind;
        e.st     = 3'(st);
        e.pwr    = 1'(pwr);
        e.pill   = 5'(pill);
        e.bottle = 10'(bottle);
        e.err    = 1'(err);
        e.gap    = gap;
        expQ.push_back(e);
    endtask

    task automatic pushWrap(input int bottle, input int gap);
        ExpWrap w;
        w.bottle = 2'(bottle);
        w.gap    = gap;
        wrapQ.push_back(w);
    endtask

    // Compare one observed event of the main controller with the head of the scoreboard.
    task automatic checkOutput(input int kind);
        ExpEvent e;
        int      gap;
        bit      bad;
        gap     = cyc - lastCyc;
        lastCyc = cyc;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL event: got unexpected kind=%0d state=%0d pill=%0d bottle=%0d err=%0d, required no event",
                     kind, o_state, o_pillCount, o_bottleCount, o_error);
        end else begin
            e = expQ.pop_front();
            bad = (kind != e.kind) || (o_state !== e.st) || (o_power !== e.pwr) ||
                  (o_pillCount !== e.pill) || (o_bottleCount !== e.bottle) ||
                  (o_error !== e.err) || (o_pillPulse !== (e.kind == K_PULSE)) ||
                  (o_change !== (e.st == 3'd3)) || (o_done !== (e.st == 3'd4)) ||
                  ((e.gap != 0) && (gap != e.gap));
            if (bad) begin
                miscompares++;
                $display("[TB] FAIL event: got kind=%0d st=%0d pwr=%0d pill=%0d bottle=%0d err=%0d pulse=%0d chg=%0d done=%0d gap=%0d, required kind=%0d st=%0d pwr=%0d pill=%0d bottle=%0d err=%0d gap=%0d",
                         kind, o_state, o_power, o_pillCount, o_bottleCount, o_error, o_pillPulse,
                         o_change, o_done, gap, e.kind, e.st, e.pwr, e.pill, e.bottle, e.err, e.gap);
            end
        end
    endtask

    // Compare one bottle-count change of the narrow-counter controller.
    task automatic checkWrap();
        ExpWrap w;
        int     gap;
        gap      = cyc - lastCyc2;
        lastCyc2 = cyc;
        vectors++;
        if (wrapQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL wrap: got unexpected bottle=%0d, required no change", o_bottleCount2);
        end else begin
            w = wrapQ.pop_front();
            if ((o_bottleCount2 !== w.bottle) || ((w.gap != 0) && (gap != w.gap)) ||
                (o_state2 !== 3'd2) || (o_done2 !== 1'b0) || (o_change2 !== 1'b0) ||
                (o_power2 !== 1'b1) || (o_error2 !== 1'b0) || (o_pillCount2 !== 5'd0) ||
                (o_pillPulse2 !== 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL wrap: got bottle=%0d gap=%0d state=%0d done=%0d pill=%0d, required bottle=%0d gap=%0d state=2 done=0 pill=0",
                         o_bottleCount2, gap, o_state2, o_done2, o_pillCount2, w.bottle, w.gap);
            end
        end
    endtask

    // Monitor: sample away from the active edge, detect events, and close the run on request.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (o_state !== prevState)
            checkOutput(K_STATE);
        else if (o_pillPulse === 1'b1)
            checkOutput(K_PULSE);
        else if (o_error !== prevErr)
            checkOutput(K_ERROR);
        prevState = o_state;
        prevErr   = o_error;
        if (o_bottleCount2 !== prevBottle2)
            checkWrap();
        prevBottle2 = o_bottleCount2;
        if (finishReq) begin
            vectors++;
            if (expQ.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL drain: got %0d pending events, required 0", expQ.size());
            end
            vectors++;
            if (wrapQ.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL wrapDrain: got %0d pending changes, required 0", wrapQ.size());
            end
            vectors++;
            if (timeouts != 0) begin
                miscompares++;
                $display("[TB] FAIL waits: got %0d expired waits, required 0", timeouts);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    task automatic waitPill(input int n);
        int g = 0;
        while (!(o_pillPulse === 1'b1 && o_pillCount == 5'(n)) && g < 400) begin
            @(negedge clock);
            g++;
        end
        if (g >= 400) timeouts++;
    endtask

    task automatic waitFlag(input bit wantDone);
        int g = 0;
        while ((wantDone ? o_done : o_change) !== 1'b1 && g < 400) begin
            @(negedge clock);
            g++;
        end
        if (g >= 400) timeouts++;
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 5'd3, 10'd2);
        powerBtn2 = 1'b0; restart2 = 1'b0; pause2 = 1'b0;
        perBottle2 = 5'd1; targetBottles2 = 2'd0;
        pushExp(K_STATE, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Two bottles of three pills, then DONE.
        pushExp(K_STATE, 1, 1, 0, 0, 0, 0);
        pushExp(K_STATE, 2, 1, 0, 0, 0, 1);
        for (int b = 0; b < 2; b++) begin
            for (int p = 1; p <= 3; p++) pushExp(K_PULSE, 2, 1, p, b, 0, 4);
            pushExp(K_STATE, 3, 1, 3, b, 0, 1);
            if (b == 0) pushExp(K_STATE, 2, 1, 0, 1, 0, 2);
        end
        pushExp(K_STATE, 4, 1, 0, 2, 0, 2);
        applyStimulus(1, 0, 0, 5'd3, 10'd2);
        repeat (4) @(negedge clock);
        applyStimulus(0, 0, 0, 5'd3, 10'd2);
        waitFlag(1'b1);
        repeat (3) @(negedge clock);

        // Restart into CHECK, illegal limits 0 and 21, then 20 is accepted.
        pushExp(K_STATE, 1, 1, 0, 0, 0, 0);
        pushExp(K_ERROR, 1, 1, 0, 0, 1, 1);
        pushExp(K_STATE, 2, 1, 0, 0, 0, 6);
        pushExp(K_PULSE, 2, 1, 1, 0, 0, 4);
        pushExp(K_PULSE, 2, 1, 2, 0, 0, 4);
        applyStimulus(0, 1, 0, 5'd0, 10'd0);
        @(negedge clock);
        applyStimulus(0, 0, 0, 5'd0, 10'd0);
        repeat (3) @(negedge clock);
        applyStimulus(0, 0, 0, 5'd21, 10'd0);
        repeat (3) @(negedge clock);
        applyStimulus(0, 0, 0, 5'd20, 10'd0);

        // Pause mid-phase for ten clocks; the tick phase must survive.
        waitPill(2);
        @(negedge clock);
        pushExp(K_PULSE, 2, 1, 3, 0, 0, 14);
        applyStimulus(0, 0, 1, 5'd20, 10'd0);
        repeat (10) @(negedge clock);
        applyStimulus(0, 0, 0, 5'd20, 10'd0);

        // Restart together with pause in FILL, new limit of two pills.
        waitPill(3);
        pushExp(K_STATE, 1, 1, 0, 0, 0, 1);
        pushExp(K_STATE, 2, 1, 0, 0, 0, 1);
        pushExp(K_PULSE, 2, 1, 1, 0, 0, 4);
        pushExp(K_PULSE, 2, 1, 2, 0, 0, 4);
        pushExp(K_STATE, 3, 1, 2, 0, 0, 1);
        applyStimulus(0, 1, 1, 5'd2, 10'd0);
        @(negedge clock);
        applyStimulus(0, 0, 1, 5'd2, 10'd0);
        @(negedge clock);
        applyStimulus(0, 0, 0, 5'd2, 10'd0);

        // Power off while held in CHANGE, with a restart landing as power drops.
        waitFlag(1'b0);
        pushExp(K_STATE, 0, 0, 0, 0, 0, 4);
        applyStimulus(1, 0, 1, 5'd2, 10'd0);
        repeat (3) @(negedge clock);
        applyStimulus(1, 1, 1, 5'd2, 10'd0);
        @(negedge clock);
        applyStimulus(0, 0, 0, 5'd2, 10'd0);
        repeat (3) @(negedge clock);

        // Power back on, then async reset in the middle of FILL.
        pushExp(K_STATE, 1, 1, 0, 0, 0, 0);
        pushExp(K_STATE, 2, 1, 0, 0, 0, 1);
        pushExp(K_PULSE, 2, 1, 1, 0, 0, 4);
        pushExp(K_STATE, 0, 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 5'd2, 10'd0);
        repeat (4) @(negedge clock);
        applyStimulus(0, 0, 0, 5'd2, 10'd0);
        waitPill(1);
        @(negedge clock);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Two-bit bottle counter, unlimited target: 1,2,3,0,1 with no DONE.
        pushWrap(1, 0);
        pushWrap(2, 7);
        pushWrap(3, 7);
        pushWrap(0, 7);
        pushWrap(1, 7);
        powerBtn2 = 1'b1;
        repeat (4) @(negedge clock);
        powerBtn2 = 1'b0;
        begin
            int g = 0;
            while (wrapQ.size() != 0 && g < 400) begin
                @(negedge clock);
                g++;
            end
            if (g >= 400) timeouts++;
        end
        pause2 = 1'b1;
        repeat (3) @(negedge clock);
        finishReq = 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
